ifetch_buffer: RTL and testbench

Instruction fetch front-end sitting directly upstream of the core datapath; it replaces the direct PC-to-instruction-memory path.
- Issues sequential word fetches to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small prefetch FIFO and presents them to the core through a valid/ready interface.
- Branch/jump redirects from the core flush the buffer and discard any in-flight response.

---
 rtl/ifetch_buffer.sv | 161 ++++++++++++++++
 tb/tb_ifetch_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buffer.sv
// Instruction fetch front-end: sequential req/ack word fetcher feeding a prefetch FIFO, flushed by core redirects.
// Optional feature macro IFETCH_BYPASS_EN: zero-cycle ack-to-core forwarding when the FIFO is empty.
module ifetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    input  logic                     instr_ready,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          imem_req_q;
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_pc_q    [DEPTH];

    logic          head_valid, ack_in_req, bypass, push, pop, space;
    logic [CW-1:0] count_next;
    logic          unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Handshake decode; "space" already accounts for this cycle's push and pop.
    always_comb begin
        head_valid = (count_q != {CW{1'b0}});
        ack_in_req = (state_q == REQ) && imem_ack;
`ifdef IFETCH_BYPASS_EN
        bypass     = !head_valid && ack_in_req && instr_ready && !redirect_valid;
`else
        bypass     = 1'b0;
`endif
        push       = ack_in_req && !redirect_valid && !bypass;
        pop        = head_valid && instr_ready && !redirect_valid;
        count_next = count_q + CW'(push) - CW'(pop);
        space      = (count_next < DEPTH_C);
    end

    // Core-facing head view; zeroed when nothing is presented.
    always_comb begin
        instr_valid = head_valid || bypass;
        if (head_valid) begin
            instr    = mem_instr_q[rd_ptr_q];
            instr_pc = mem_pc_q[rd_ptr_q];
        end else if (bypass) begin
            instr    = imem_rdata;
            instr_pc = req_addr_q;
        end else begin
            instr    = 32'h0000_0000;
            instr_pc = 32'h0000_0000;
        end
    end

    // Next-state: redirect flushes the FIFO and overrides everything else.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        if (redirect_valid) begin
            count_d    = {CW{1'b0}};
            rd_ptr_d   = {AW{1'b0}};
            wr_ptr_d   = {AW{1'b0}};
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else begin
            count_d  = count_next;
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
            if (ack_in_req) begin
                fetch_pc_d = req_addr_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
        end
        case (state_q)
            IDLE: begin
                if (!redirect_valid && space) begin
                    state_d    = REQ;
                    req_addr_d = fetch_pc_q;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    state_d = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    if (space) begin
                        state_d    = REQ;
                        req_addr_d = req_addr_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            DROP: begin
                state_d = imem_ack ? IDLE : DROP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and registered request outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            count_q    <= {CW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            imem_req_q <= (state_d != IDLE);
        end
    end

    // FIFO storage needs no reset: the head is masked while count is zero.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_instr_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]    <= req_addr_q;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = req_addr_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: table-driven latency/backpressure runs plus hand-written redirect/reset sequences.
module tb_ifetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_ready;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] fifo_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        int   lat;
        logic ready;
        int   ncyc;
        int   exp_deliv;
        int   exp_count;
        logic exp_req;
    } vec_t;

    ent_t        sbq[$];
    vec_t        vecs[5];
    int          checks = 0;
    int          errors = 0;
    int          n_deliv = 0;
    int          mem_lat = 0;
    int          mem_cnt = 0;
    logic        mem_on;
    logic        man_ack;
    logic [31:0] man_rdata;
    logic [31:0] exp_fetch;
    logic [31:0] drop_addr;
    logic        drop_pending;

    ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_F00F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Scoreboard: fetched words are queued in fetch order, popped when the core consumes.
    task automatic score();
        ent_t e;
        if (reset) begin
            sbq.delete();
            exp_fetch    = RESET_PC;
            drop_pending = 1'b0;
            n_deliv      = 0;
        end else begin
            check("fifo_count", 32'(fifo_count), 32'(sbq.size()));
            check("instr_valid", 32'(instr_valid), 32'(sbq.size() != 0));
            if (instr_valid && instr_ready && !redirect_valid) begin
                n_deliv++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h required none", instr_pc);
                end else begin
                    e = sbq.pop_front();
                    check("instr_pc", instr_pc, e.pc);
                    check("instr", instr, e.data);
                end
            end
            if (imem_req && imem_ack) begin
                if (drop_pending) begin
                    check("drop_addr", imem_addr, drop_addr);
                    drop_pending = 1'b0;
                end else if (!redirect_valid) begin
                    check("fetch_addr", imem_addr, exp_fetch);
                    sbq.push_back({exp_fetch, mem_word(exp_fetch)});
                    exp_fetch = exp_fetch + 32'd4;
                end
            end else if (imem_req && redirect_valid) begin
                drop_pending = 1'b1;
                drop_addr    = imem_addr;
            end
            if (redirect_valid) begin
                sbq.delete();
                exp_fetch = {redirect_pc[31:2], 2'b00};
            end
        end
    endtask

    // One clock: memory responds at negedge, scoreboard samples, then return just after posedge.
    task automatic step();
        @(negedge clk);
        if (mem_on) begin
            if (imem_req && mem_cnt >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                mem_cnt    = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'h0000_0000;
                mem_cnt    = imem_req ? mem_cnt + 1 : 0;
            end
        end else begin
            imem_ack   = man_ack;
            imem_rdata = man_rdata;
            mem_cnt    = 0;
        end
        #1;
        score();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; mem_on = 1'b1; man_ack = 1'b0;
        man_rdata = 32'h0; exp_fetch = RESET_PC; drop_pending = 1'b0; drop_addr = 32'h0;

        vecs[0] = '{lat: 0, ready: 1'b1, ncyc: 20, exp_deliv: 18, exp_count: 1, exp_req: 1'b1};
        vecs[1] = '{lat: 1, ready: 1'b1, ncyc: 20, exp_deliv: 9,  exp_count: 0, exp_req: 1'b1};
        vecs[2] = '{lat: 3, ready: 1'b1, ncyc: 20, exp_deliv: 4,  exp_count: 0, exp_req: 1'b1};
        vecs[3] = '{lat: 3, ready: 1'b0, ncyc: 20, exp_deliv: 0,  exp_count: 4, exp_req: 1'b0};
        vecs[4] = '{lat: 0, ready: 1'b0, ncyc: 20, exp_deliv: 0,  exp_count: 4, exp_req: 1'b0};

        // Reset values while held in reset
        step();
        step();
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_fifo_count", 32'(fifo_count), 32'h0);

        for (int i = 0; i < 5; i++) begin
            mem_on      = 1'b1;
            mem_lat     = vecs[i].lat;
            instr_ready = vecs[i].ready;
            do_reset();
            repeat (vecs[i].ncyc) step();
            check($sformatf("v%0d_delivered", i), 32'(n_deliv), 32'(vecs[i].exp_deliv));
            check($sformatf("v%0d_fifo_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
            check($sformatf("v%0d_imem_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
        end

        // Drain the full FIFO: 0,4,8,C in order, then fetching resumes at 0x10
        instr_ready = 1'b1;
        repeat (10) step();
        check("drain_delivered", 32'(n_deliv), 32'd10);

        // Redirect one cycle after a 3-wait request to 0x8 forces a discarded response
        mem_lat = 3;
        do_reset();
        repeat (10) step();
        check("drop_pre_addr", imem_addr, 32'h0000_0008);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        check("drop_count", 32'(fifo_count), 32'h0);
        check("drop_hold_req", 32'(imem_req), 32'h1);
        check("drop_hold_addr", imem_addr, 32'h0000_0008);
        repeat (3) step();
        check("drop_new_req", 32'(imem_req), 32'h1);
        check("drop_new_addr", imem_addr, 32'h0000_0100);
        repeat (8) step();

        // Redirect in the same cycle as an ack and a pop, two entries buffered
        mem_lat     = 0;
        instr_ready = 1'b0;
        do_reset();
        repeat (3) step();
        check("same_pre_count", 32'(fifo_count), 32'd2);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        check("same_valid", 32'(instr_valid), 32'h0);
        check("same_count", 32'(fifo_count), 32'h0);
        step();
        check("same_new_req", 32'(imem_req), 32'h1);
        check("same_new_addr", imem_addr, 32'h0000_0040);
        repeat (5) step();

        // Reset while a request is outstanding, ack arriving during reset and then in IDLE
        mem_on  = 1'b0;
        man_ack = 1'b0;
        do_reset();
        step();
        check("first_req", 32'(imem_req), 32'h1);
        check("first_addr", imem_addr, RESET_PC);
        reset     = 1'b1;
        man_ack   = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        step();
        check("mid_rst_req", 32'(imem_req), 32'h0);
        check("mid_rst_addr", imem_addr, RESET_PC);
        check("mid_rst_valid", 32'(instr_valid), 32'h0);
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_pc", instr_pc, 32'h0);
        check("mid_rst_count", 32'(fifo_count), 32'h0);
        reset = 1'b0;
        step();
        check("idle_ack_count", 32'(fifo_count), 32'h0);
        check("post_rst_req", 32'(imem_req), 32'h1);
        check("post_rst_addr", imem_addr, RESET_PC);
        man_ack = 1'b0;
        mem_on  = 1'b1;
        repeat (6) step();

        // Redirect alignment and 32-bit PC wrap
        do_reset();
        repeat (5) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        step();
        check("align_addr", imem_addr, 32'h0000_0200);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        check("wrap_first_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_second_addr", imem_addr, 32'h0000_0000);
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
